// File: rtl/line_stream_reader.sv
// line_stream_reader
// Reads the LEN words of one transform line from the character ROM and
// streams each word as an (lhs, rhs) character pair.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   start, line_ptr      begin a line; line_ptr = {len, base}, sampled only in IDLE
//   busy, done           busy from accepted start through the done pulse
//   mem_rd, mem_addr     ROM read strobe and address (address all-ones when idle)
//   mem_dout             ROM data, valid MEM_LAT cycles after its mem_rd cycle
//   out_valid/out_ready  output handshake (see below)
//   out_lhs, out_rhs     characters of the head word
//   out_last, out_idx    head word is the final one / its index within the line
//   dbg_state            current FSM state, for observation only
//
// Handshake: a pair moves when out_valid && out_ready are both high on a rising
// edge. Once out_valid is raised it stays high, and out_* stay unchanged, until
// that transfer happens.
//
// Reads are only issued while every outstanding word (reads in the return pipe
// plus words in the buffer) still has a guaranteed buffer slot, so back-pressure
// stalls the ROM reads instead of overflowing the buffer.
module line_stream_reader #(
    parameter int ADDR_W  = 8,
    parameter int CHAR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int BUF_D   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*ADDR_W-1:0] line_ptr,
    output logic                busy,
    output logic                done,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [2*CHAR_W-1:0] mem_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHAR_W-1:0]   out_lhs,
    output logic [CHAR_W-1:0]   out_rhs,
    output logic                out_last,
    output logic [ADDR_W-1:0]   out_idx,
    output logic [1:0]          dbg_state
);

    localparam int PW = (BUF_D > 1) ? $clog2(BUF_D) : 1;
    localparam int CW = $clog2(BUF_D + 1);
    localparam int SW = $clog2(BUF_D + MEM_LAT + 2) + 1;
    localparam int DW = 2 * CHAR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_r, len_r, k_r, iss_idx;

    // Return-path tags: tag_v[0] is the read issued last cycle; the word tagged
    // in tag_v[MEM_LAT-1] is on mem_dout this cycle.
    logic [MEM_LAT-1:0] tag_v;
    logic [ADDR_W-1:0]  tag_idx [MEM_LAT];

    logic [DW-1:0]     buf_data [BUF_D];
    logic [ADDR_W-1:0] buf_idx  [BUF_D];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, count_next;

    logic              arrival, buf_empty, pop, buf_wr, buf_rd;
    logic [ADDR_W-1:0] arr_idx, head_idx;
    logic [DW-1:0]     head_data;
    logic [SW-1:0]     early;
    logic              early_pend, can_issue, drain_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign dbg_state = state;
    assign arrival   = tag_v[MEM_LAT-1];
    assign arr_idx   = tag_idx[MEM_LAT-1];

    // First-word-fall-through with bypass: when the buffer is empty the arriving
    // ROM word is presented directly; if it is not taken it lands in the buffer
    // and stays at the head, so the pair seen downstream does not change.
    always_comb begin
        buf_empty  = (count == '0);
        out_valid  = !buf_empty || arrival;
        head_data  = buf_empty ? mem_dout : buf_data[rd_ptr];
        head_idx   = buf_empty ? arr_idx  : buf_idx[rd_ptr];
        pop        = out_valid && out_ready;
        buf_wr     = arrival && !(buf_empty && pop);
        buf_rd     = pop && !buf_empty;
        count_next = count + CW'(buf_wr) - CW'(buf_rd);
        out_lhs    = out_valid ? head_data[DW-1:CHAR_W] : '0;
        out_rhs    = out_valid ? head_data[CHAR_W-1:0]  : '0;
        out_idx    = out_valid ? head_idx : '0;
        out_last   = out_valid && (head_idx == len_r - ADDR_W'(1));
    end

    // Reads that will still be outstanding after this edge, excluding the one
    // arriving now (already counted in count_next).
    always_comb begin
        early      = SW'(mem_rd);
        early_pend = mem_rd;
        for (int i = 0; i < MEM_LAT - 1; i++) begin
            early      = early + SW'(tag_v[i]);
            early_pend = early_pend | tag_v[i];
        end
        can_issue = (early + SW'(count_next)) < SW'(BUF_D);
        // Counting the pop in progress lets done follow the last transfer directly.
        drain_ok  = !early_pend && (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '1;
            base_r   <= '0;
            len_r    <= '0;
            k_r      <= '0;
            iss_idx  <= '0;
        end else begin
            mem_rd   <= 1'b0;
            mem_addr <= '1;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_r <= line_ptr[ADDR_W-1:0];
                        len_r  <= line_ptr[2*ADDR_W-1:ADDR_W];
                        k_r    <= '0;
                        busy   <= 1'b1;
                        if (line_ptr[2*ADDR_W-1:ADDR_W] == '0) begin
                            // Empty line: nothing to fetch, done right away.
                            done  <= 1'b1;
                            state <= S_DRAIN;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (can_issue) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= base_r + k_r;
                        iss_idx  <= k_r;
                        k_r      <= k_r + ADDR_W'(1);
                        if (k_r == len_r - ADDR_W'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (drain_ok) begin
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            for (int i = 0; i < MEM_LAT; i++) tag_idx[i] <= '0;
        end else begin
            tag_v[0]   <= mem_rd;
            tag_idx[0] <= iss_idx;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (buf_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (buf_rd) rd_ptr <= ptr_inc(rd_ptr);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_wr) begin
            buf_data[wr_ptr] <= mem_dout;
            buf_idx[wr_ptr]  <= arr_idx;
        end
    end

endmodule

// File: tb/tb_line_stream_reader.sv
module tb_line_stream_reader;

    localparam int BUF_D = 4;

    logic        clk = 1'b0;
    logic        rst, start, out_ready, clr;
    logic [15:0] line_ptr;

    logic        busy_w [2], done_w [2], mem_rd_w [2], out_valid_w [2], out_last_w [2];
    logic [7:0]  mem_addr_w [2], out_lhs_w [2], out_rhs_w [2], out_idx_w [2];
    logic [15:0] mem_dout_w [2];
    logic [1:0]  dbg_w [2];
    logic [24:0] cur_w [2];

    // clock
    always #5 clk = ~clk;

    // u0: MEM_LAT=1, u1: MEM_LAT=3, same stimulus
    line_stream_reader #(.ADDR_W(8), .CHAR_W(8), .MEM_LAT(1), .BUF_D(BUF_D)) dut0 (
        .clk(clk), .rst(rst), .start(start), .line_ptr(line_ptr),
        .busy(busy_w[0]), .done(done_w[0]), .mem_rd(mem_rd_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_dout(mem_dout_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_lhs(out_lhs_w[0]), .out_rhs(out_rhs_w[0]), .out_last(out_last_w[0]),
        .out_idx(out_idx_w[0]), .dbg_state(dbg_w[0]));

    line_stream_reader #(.ADDR_W(8), .CHAR_W(8), .MEM_LAT(3), .BUF_D(BUF_D)) dut1 (
        .clk(clk), .rst(rst), .start(start), .line_ptr(line_ptr),
        .busy(busy_w[1]), .done(done_w[1]), .mem_rd(mem_rd_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_dout(mem_dout_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_lhs(out_lhs_w[1]), .out_rhs(out_rhs_w[1]), .out_last(out_last_w[1]),
        .out_idx(out_idx_w[1]), .dbg_state(dbg_w[1]));

    assign cur_w[0] = {out_last_w[0], out_idx_w[0], out_lhs_w[0], out_rhs_w[0]};
    assign cur_w[1] = {out_last_w[1], out_idx_w[1], out_lhs_w[1], out_rhs_w[1]};

    // ROM model: data for the read strobed in cycle c shows up in cycle c+lat,
    // garbage otherwise; never reset so late data keeps coming after a reset.
    logic [15:0] rom [256];
    logic        rp_v [2][3];
    logic [7:0]  rp_a [2][3];
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            rp_v[u][0] <= mem_rd_w[u];
            rp_a[u][0] <= mem_addr_w[u];
            for (int i = 1; i < 3; i++) begin
                rp_v[u][i] <= rp_v[u][i-1];
                rp_a[u][i] <= rp_a[u][i-1];
            end
        end
    end
    assign mem_dout_w[0] = rp_v[0][0] ? rom[rp_a[0][0]] : 16'hDEAD;
    assign mem_dout_w[1] = rp_v[1][2] ? rom[rp_a[1][2]] : 16'hDEAD;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: logs issued addresses, accepted pairs, done pulses, rule breaks
    int          n_acc [2], n_addr [2], n_done [2], n_val [2];
    int          stab_err [2], ovf_err [2], addr_err [2], busy_err [2];
    int          first_rd [2], first_val [2], done_cyc [2];
    logic [24:0] acc_log [2][512];
    int          acc_cyc [2][512];
    logic [7:0]  addr_log [2][512];
    logic        hold [2];
    logic [24:0] held [2];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (clr) begin
                n_acc[u] <= 0; n_addr[u] <= 0; n_done[u] <= 0; n_val[u] <= 0;
                stab_err[u] <= 0; ovf_err[u] <= 0; addr_err[u] <= 0; busy_err[u] <= 0;
                first_rd[u] <= -1; first_val[u] <= -1; done_cyc[u] <= -1; hold[u] <= 1'b0;
            end else begin
                if (mem_rd_w[u] === 1'b1) begin
                    if (n_addr[u] < 512) addr_log[u][n_addr[u]] <= mem_addr_w[u];
                    if (n_addr[u] == 0) first_rd[u] <= cyc;
                    n_addr[u] <= n_addr[u] + 1;
                end else if (mem_addr_w[u] !== 8'hFF) begin
                    addr_err[u] <= addr_err[u] + 1;
                end
                if (n_addr[u] + (mem_rd_w[u] ? 1 : 0) - n_acc[u] > BUF_D) ovf_err[u] <= ovf_err[u] + 1;
                if (out_valid_w[u] === 1'b1) begin
                    if (n_val[u] == 0) first_val[u] <= cyc;
                    n_val[u] <= n_val[u] + 1;
                    if (hold[u] && cur_w[u] !== held[u]) stab_err[u] <= stab_err[u] + 1;
                    if (out_ready) begin
                        if (n_acc[u] < 512) begin
                            acc_log[u][n_acc[u]] <= cur_w[u];
                            acc_cyc[u][n_acc[u]] <= cyc;
                        end
                        n_acc[u] <= n_acc[u] + 1;
                        hold[u]  <= 1'b0;
                    end else begin
                        hold[u] <= 1'b1;
                        held[u] <= cur_w[u];
                    end
                end else if (hold[u]) begin
                    stab_err[u] <= stab_err[u] + 1;
                    hold[u]     <= 1'b0;
                end
                if (done_w[u] === 1'b1) begin
                    n_done[u]   <= n_done[u] + 1;
                    done_cyc[u] <= cyc;
                    if (busy_w[u] !== 1'b1) busy_err[u] <= busy_err[u] + 1;
                end
            end
        end
    end

    // scoreboard
    logic [24:0] exp_q [$];
    logic [7:0]  exp_addr_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          start_cyc;
    bit          timed_out;

    task automatic clear_logs();
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    function automatic logic pick_ready(input int mode, input int t);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (t % 3 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    // Drives one line and fills the expected queues from the ROM contents:
    // word k comes from ROM[(base+k) mod 256], idx k, last on k==len-1.
    task automatic run_line(input logic [15:0] ptr, input int mode, input bit hold_start);
        int t;
        logic [7:0] b, l, a;
        b = ptr[7:0];
        l = ptr[15:8];
        exp_q.delete();
        exp_addr_q.delete();
        for (int k = 0; k < int'(l); k++) begin
            a = b + 8'(k);
            exp_addr_q.push_back(a);
            exp_q.push_back({(k == int'(l) - 1), 8'(k), rom[a]});
        end
        clear_logs();
        @(posedge clk); #1;
        line_ptr  = ptr;
        start     = 1'b1;
        start_cyc = cyc;
        out_ready = pick_ready(mode, 0);
        t = 0;
        while (t < 3000 && !(n_done[0] > 0 && n_done[1] > 0)) begin
            @(posedge clk); #1;
            t++;
            if (!hold_start || n_done[0] > 0 || n_done[1] > 0) start = 1'b0;
            out_ready = pick_ready(mode, t);
        end
        timed_out = (t >= 3000);
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; line_ptr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({busy_w[u], done_w[u], mem_rd_w[u], mem_addr_w[u], out_valid_w[u], cur_w[u]} !==
                {1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 25'h0}) begin
                n_fail++;
                $display("FAIL reset_values u%0d: got busy=%b done=%b rd=%b addr=%h valid=%b pair=%h, expected 0 0 0 ff 0 0",
                         u, busy_w[u], done_w[u], mem_rd_w[u], mem_addr_w[u], out_valid_w[u], cur_w[u]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        rom[3] = 16'h3131; rom[4] = 16'h3173; rom[5] = 16'h7320;
        run_line({8'h03, 8'h03}, 0, 1'b0);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (timed_out || n_acc[u] != 3) begin
                n_fail++; $display("FAIL basic_count u%0d: got %0d pairs, expected 3", u, n_acc[u]);
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (acc_log[u][i] !== exp_q[i] || addr_log[u][i] !== exp_addr_q[i]) begin
                    n_fail++; $display("FAIL basic_pair u%0d i%0d: got %h@%h, expected %h@%h",
                                       u, i, acc_log[u][i], addr_log[u][i], exp_q[i], exp_addr_q[i]);
                end
            end
            n_checks++;
            if (first_val[u] - first_rd[u] != (u == 0 ? 1 : 3)) begin
                n_fail++; $display("FAIL basic_latency u%0d: got %0d, expected %0d", u, first_val[u] - first_rd[u], (u == 0 ? 1 : 3));
            end
            n_checks++;
            if (acc_cyc[u][1] != acc_cyc[u][0] + 1 || acc_cyc[u][2] != acc_cyc[u][0] + 2) begin
                n_fail++; $display("FAIL basic_throughput u%0d: got cycles %0d %0d %0d, expected consecutive",
                                   u, acc_cyc[u][0], acc_cyc[u][1], acc_cyc[u][2]);
            end
            n_checks++;
            if (n_done[u] != 1 || done_cyc[u] != acc_cyc[u][2] + 1 || busy_err[u] != 0 || addr_err[u] != 0) begin
                n_fail++; $display("FAIL basic_done u%0d: got %0d pulses at %0d (busy_err %0d addr_err %0d), expected 1 at %0d",
                                   u, n_done[u], done_cyc[u], busy_err[u], addr_err[u], acc_cyc[u][2] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 4; r++) begin
            if (r == 0) run_line({8'h03, 8'h03}, 1, 1'b0);
            else run_line({8'($urandom_range(1, 12)), 8'($urandom_range(0, 255))}, (r == 1) ? 1 : 2, 1'b0);
            for (int u = 0; u < 2; u++) begin
                n_checks++;
                if (timed_out || n_acc[u] != exp_q.size() || n_addr[u] != exp_q.size()) begin
                    n_fail++; $display("FAIL bp_count r%0d u%0d: got %0d pairs %0d reads, expected %0d",
                                       r, u, n_acc[u], n_addr[u], exp_q.size());
                end
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (acc_log[u][i] !== exp_q[i]) begin
                        n_fail++; $display("FAIL bp_pair r%0d u%0d i%0d: got %h, expected %h", r, u, i, acc_log[u][i], exp_q[i]);
                    end
                end
                n_checks++;
                if (stab_err[u] != 0 || ovf_err[u] != 0 || n_done[u] != 1) begin
                    n_fail++; $display("FAIL bp_rules r%0d u%0d: got stab %0d ovf %0d done %0d, expected 0 0 1",
                                       r, u, stab_err[u], ovf_err[u], n_done[u]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        run_line({8'h00, 8'h05}, 0, 1'b0);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (n_addr[u] != 0 || n_val[u] != 0) begin
                n_fail++; $display("FAIL zero_activity u%0d: got %0d reads %0d valid cycles, expected 0 0", u, n_addr[u], n_val[u]);
            end
            n_checks++;
            if (n_done[u] != 1 || done_cyc[u] != start_cyc + 1) begin
                n_fail++; $display("FAIL zero_done u%0d: got %0d pulses at %0d, expected 1 at %0d", u, n_done[u], done_cyc[u], start_cyc + 1);
            end
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 2; r++) begin
            run_line({8'h03, 8'hFE}, r * 2, 1'b0);
            for (int u = 0; u < 2; u++) begin
                n_checks++;
                if (n_addr[u] != 3 || addr_log[u][0] !== 8'hFE || addr_log[u][1] !== 8'hFF || addr_log[u][2] !== 8'h00) begin
                    n_fail++; $display("FAIL wrap_addr r%0d u%0d: got %0d reads %h %h %h, expected 3 reads fe ff 00",
                                       r, u, n_addr[u], addr_log[u][0], addr_log[u][1], addr_log[u][2]);
                end
                for (int i = 0; i < 3; i++) begin
                    n_checks++;
                    if (acc_log[u][i] !== exp_q[i] || n_acc[u] != 3) begin
                        n_fail++; $display("FAIL wrap_pair r%0d u%0d i%0d: got %h (n=%0d), expected %h", r, u, i, acc_log[u][i], n_acc[u], exp_q[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        int t;
        clear_logs();
        @(posedge clk); #1;
        line_ptr = {8'h06, 8'h10}; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (t < 50 && n_addr[1] < 2) begin
            @(negedge clk); #1;
            t++;
        end
        n_checks++;
        if (n_addr[1] < 2) begin
            n_fail++; $display("FAIL rstmid_reads: got %0d reads before reset, expected 2", n_addr[1]);
        end
        rst = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({busy_w[u], done_w[u], mem_rd_w[u], mem_addr_w[u], out_valid_w[u], cur_w[u]} !==
                {1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 25'h0}) begin
                n_fail++;
                $display("FAIL rstmid_values u%0d: got busy=%b done=%b rd=%b addr=%h valid=%b pair=%h, expected 0 0 0 ff 0 0",
                         u, busy_w[u], done_w[u], mem_rd_w[u], mem_addr_w[u], out_valid_w[u], cur_w[u]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        repeat (12) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (n_val[u] != 0 || n_done[u] != 0 || n_addr[u] != 0 || busy_w[u] !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_quiet u%0d: got valid %0d done %0d reads %0d busy %b, expected 0 0 0 0",
                                   u, n_val[u], n_done[u], n_addr[u], busy_w[u]);
            end
        end
        run_line({8'h05, 8'h20}, 2, 1'b0);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (n_acc[u] != 5 || n_done[u] != 1) begin
                n_fail++; $display("FAIL rstmid_after_count u%0d: got %0d pairs %0d done, expected 5 1", u, n_acc[u], n_done[u]);
            end
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (acc_log[u][i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rstmid_after_pair u%0d i%0d: got %h, expected %h", u, i, acc_log[u][i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_start_held();
        run_line({8'h04, 8'h40}, 0, 1'b1);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (n_addr[u] != 4 || n_acc[u] != 4 || n_done[u] != 1 || busy_w[u] !== 1'b0) begin
                n_fail++; $display("FAIL held_once u%0d: got %0d reads %0d pairs %0d done busy %b, expected 4 4 1 0",
                                   u, n_addr[u], n_acc[u], n_done[u], busy_w[u]);
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (acc_log[u][i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL held_pair u%0d i%0d: got %h, expected %h", u, i, acc_log[u][i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; line_ptr = '0; clr = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_reset_midline();
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
